// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin fifo read scheduler.
package fifo_rr_scheduler_pkg;

  typedef enum logic {
    SCHED_IDLE  = 1'b0,
    SCHED_DRAIN = 1'b1
  } sched_state_t;

  // Ceiling log2 with a floor of 1 so single-entry fields stay one bit wide.
  function automatic int log2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Fifo-bank side and consumer side of the scheduler, bundled as one interface.
interface fifo_rr_scheduler_if #(
  parameter int num_queues = 4,
  parameter int data_width = 8,
  parameter int sel_width  = 2
);

  logic [num_queues-1:0]            q_empty;
  logic [num_queues*data_width-1:0] q_dout;
  logic [num_queues-1:0]            q_rd_en;
  logic                             out_valid;
  logic                             out_ready;
  logic [data_width-1:0]            out_data;
  logic [sel_width-1:0]             out_qid;

  modport master (
    input  q_empty, q_dout, out_ready,
    output q_rd_en, out_valid, out_data, out_qid
  );

  modport slave (
    output q_empty, q_dout, out_ready,
    input  q_rd_en, out_valid, out_data, out_qid
  );

endinterface

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after 'last', wrapping.
module rr_arbiter #(
  parameter int num_queues = 4,
  parameter int sel_width  = 2
) (
  input  logic [num_queues-1:0] req,
  input  logic [sel_width-1:0]  last,
  output logic [sel_width-1:0]  winner,
  output logic                  any_req
);

  logic                 found;
  logic [sel_width-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= num_queues; k++) begin
      idx = sel_width'((int'(last) + k) % num_queues);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains a bank of fifos into one registered valid/ready stream, round-robin with bounded bursts.
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int num_queues = 4,
  parameter int data_width = 8,
  parameter int burst_max  = 4,
  parameter int sel_width  = log2(num_queues),
  parameter int cnt_width  = log2(burst_max) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_rr_scheduler_if.master  bus,
  output logic                 busy
);

  sched_state_t          state, state_next;
  logic [sel_width-1:0]  grant, last_grant, winner;
  logic [cnt_width-1:0]  burst_cnt;
  logic                  any_req;
  logic                  slot_free, head_empty, pop, burst_done, drain_exit, start_grant;
  logic [data_width-1:0] head_data;
  logic [num_queues-1:0] rd_en;
  logic                  out_valid;
  logic [data_width-1:0] out_data;
  logic [sel_width-1:0]  out_qid;

  rr_arbiter #(
    .num_queues(num_queues),
    .sel_width (sel_width)
  ) u_arb (
    .req    (~bus.q_empty),
    .last   (last_grant),
    .winner (winner),
    .any_req(any_req)
  );

  assign head_empty = bus.q_empty[grant];
  assign head_data  = bus.q_dout[int'(grant)*data_width +: data_width];
  assign slot_free  = !out_valid || bus.out_ready;

  // Pop is gated by rst so no word leaves a fifo while the scheduler is being cleared.
  assign pop         = (state == SCHED_DRAIN) && slot_free && enable && !head_empty && !rst;
  assign burst_done  = pop && (burst_cnt + cnt_width'(1) == cnt_width'(burst_max));
  assign drain_exit  = (state == SCHED_DRAIN) &&
                       (burst_done || (slot_free && head_empty) || !enable);
  assign start_grant = (state == SCHED_IDLE) && enable && any_req;

  always_comb begin
    rd_en = '0;
    if (pop) rd_en[grant] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      SCHED_IDLE:  if (start_grant) state_next = SCHED_DRAIN;
      SCHED_DRAIN: if (drain_exit)  state_next = SCHED_IDLE;
      default:     state_next = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCHED_IDLE;
      grant      <= '0;
      burst_cnt  <= '0;
      last_grant <= sel_width'(num_queues - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_qid    <= '0;
    end else begin
      state <= state_next;
      if (start_grant) begin
        grant     <= winner;
        burst_cnt <= '0;
      end
      if (pop) burst_cnt <= burst_cnt + cnt_width'(1);
      // The pointer only moves on leaving DRAIN, so a lone active queue keeps winning.
      if (drain_exit) last_grant <= grant;
      if (pop) begin
        out_data  <= head_data;
        out_qid   <= grant;
        out_valid <= 1'b1;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.q_rd_en   = rd_en;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_qid   = out_qid;
  assign busy          = (state == SCHED_DRAIN) || out_valid;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with a behavioural fifo bank and consumer.
module tb_fifo_rr_scheduler;

  localparam int NQ = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic busy;

  fifo_rr_scheduler_if #(.num_queues(NQ), .data_width(DW), .sel_width(SW)) bus ();

  fifo_rr_scheduler #(
    .num_queues(NQ),
    .data_width(DW),
    .burst_max (BM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .bus   (bus.master),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq [NQ][$];
  logic [DW-1:0] rx_data [$];
  int            rx_qid [$];
  int            run_log [$];
  int run_q, run_len, pop_cnt, first_pop_q, first_cyc, last_cyc, cyc;
  int n_checks, n_errors, onehot_err, underflow_err;
  logic [NQ-1:0] rd_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NQ; i++) begin
      bus.q_empty[i]         = (fq[i].size() == 0);
      bus.q_dout[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic close_run();
    if (run_len > 0) run_log.push_back(run_q*16 + run_len);
    run_len = 0;
  endtask

  // Observe at the falling edge, then apply the fifo pops just after the rising edge.
  task automatic step();
    int p;
    @(negedge clk);
    cyc++;
    rd_s = bus.q_rd_en;
    if (!rst && bus.out_valid && bus.out_ready) begin
      rx_data.push_back(bus.out_data);
      rx_qid.push_back(int'(bus.out_qid));
    end
    if ($countones(rd_s) > 1) onehot_err++;
    if (rd_s != '0) begin
      p = 0;
      for (int i = 0; i < NQ; i++) if (rd_s[i]) p = i;
      if (pop_cnt == 0) begin
        first_pop_q = p;
        first_cyc   = cyc;
      end
      last_cyc = cyc;
      pop_cnt++;
      if (run_len > 0 && p == run_q) run_len++;
      else begin
        close_run();
        run_q   = p;
        run_len = 1;
      end
    end else begin
      close_run();
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (rd_s[i]) begin
        if (fq[i].size() == 0) underflow_err++;
        else void'(fq[i].pop_front());
      end
    end
    refresh();
  endtask

  task automatic clear_logs();
    rx_data.delete();
    rx_qid.delete();
    run_log.delete();
    run_len = 0;
    pop_cnt = 0;
  endtask

  task automatic load(input int q, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) fq[q].push_back(base + DW'(k));
    refresh();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NQ; i++) fq[i].delete();
    refresh();
    step();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < max) begin
      pending = bus.out_valid || busy;
      for (int i = 0; i < NQ; i++) if (fq[i].size() != 0) pending = 1'b1;
      if (pending) begin
        step();
        n++;
      end
    end
    check({tag, "_drained"}, 32'(n < max), 32'd1);
  endtask

  task automatic check_runs(input string tag, input int exp[$]);
    check({tag, "_nruns"}, run_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < run_log.size(); i++)
      check($sformatf("%s_run%0d", tag, i), run_log[i], exp[i]);
  endtask

  task automatic check_rx(input string tag, input int exp_d[$], input int exp_q[$]);
    check({tag, "_nwords"}, rx_data.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < rx_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), rx_data[i], exp_d[i]);
      check($sformatf("%s_qid%0d", tag, i), rx_qid[i], exp_q[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ed[$];
    int eq[$];
    int er[$];
    int n;
    n_checks = 0; n_errors = 0; onehot_err = 0; underflow_err = 0;
    cyc = 0; run_q = 0; first_pop_q = -1; first_cyc = 0; last_cyc = 0;
    clear_logs();

    // Reset state
    do_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_qid", bus.out_qid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", bus.q_rd_en, 0);

    // Single queue, 10 words: bursts 4,4,2 with one idle cycle between
    do_reset();
    load(0, 10, 8'h10);
    enable = 1'b1;
    wait_drain("t1", 60);
    er = '{4, 4, 2};
    check_runs("t1", er);
    check("t1_span", last_cyc - first_cyc + 1, 12);
    ed.delete(); eq.delete();
    for (int k = 0; k < 10; k++) begin ed.push_back(8'h10 + k); eq.push_back(0); end
    check_rx("t1", ed, eq);

    // Four queues of 8: grant order 0,1,2,3,0,1,2,3
    do_reset();
    for (int q = 0; q < NQ; q++) load(q, 8, 8'(q*8'h40));
    enable = 1'b1;
    wait_drain("t2", 100);
    er.delete(); ed.delete(); eq.delete();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < NQ; q++) begin
        er.push_back(q*16 + 4);
        for (int k = 0; k < 4; k++) begin ed.push_back(q*8'h40 + r*4 + k); eq.push_back(q); end
      end
    check_runs("t2", er);
    check_rx("t2", ed, eq);

    // Consumer stall on q1
    do_reset();
    bus.out_ready = 1'b0;
    load(1, 6, 8'h30);
    enable = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 10) begin step(); n++; end
    check("t3_first_valid", 32'(n < 10), 32'd1);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t3_stall_valid%0d", s), bus.out_valid, 1);
      check($sformatf("t3_stall_data%0d", s), bus.out_data, 8'h30);
      check($sformatf("t3_stall_rd%0d", s), bus.q_rd_en, 0);
      step();
    end
    bus.out_ready = 1'b1;
    wait_drain("t3", 40);
    ed.delete(); eq.delete();
    for (int k = 0; k < 6; k++) begin ed.push_back(8'h30 + k); eq.push_back(1); end
    check_rx("t3", ed, eq);

    // q2 ends early on empty, q3 follows
    do_reset();
    load(2, 2, 8'hA0);
    load(3, 6, 8'hB0);
    enable = 1'b1;
    wait_drain("t4", 60);
    er = '{2*16 + 2, 3*16 + 4, 3*16 + 2};
    check_runs("t4", er);
    ed.delete(); eq.delete();
    for (int k = 0; k < 2; k++) begin ed.push_back(8'hA0 + k); eq.push_back(2); end
    for (int k = 0; k < 6; k++) begin ed.push_back(8'hB0 + k); eq.push_back(3); end
    check_rx("t4", ed, eq);

    // Enable dropped mid-burst
    do_reset();
    load(0, 8, 8'h50);
    load(1, 4, 8'h60);
    enable = 1'b1;
    n = 0;
    while (pop_cnt < 2 && n < 20) begin step(); n++; end
    enable = 1'b0;
    #1;
    check("t5_rd_on_drop", bus.q_rd_en, 0);
    step();
    check("t5_busy_idle", busy, 0);
    check("t5_valid_idle", bus.out_valid, 0);
    check("t5_pending_delivered", rx_data.size(), 2);
    step();
    step();
    check("t5_rd_disabled", bus.q_rd_en, 0);
    enable = 1'b1;
    wait_drain("t5", 80);
    er = '{0*16 + 2, 1*16 + 4, 0*16 + 4, 0*16 + 2};
    check_runs("t5", er);
    ed.delete(); eq.delete();
    for (int k = 0; k < 2; k++) begin ed.push_back(8'h50 + k); eq.push_back(0); end
    for (int k = 0; k < 4; k++) begin ed.push_back(8'h60 + k); eq.push_back(1); end
    for (int k = 2; k < 8; k++) begin ed.push_back(8'h50 + k); eq.push_back(0); end
    check_rx("t5", ed, eq);

    // Reset mid-burst
    do_reset();
    load(1, 8, 8'h70);
    load(3, 4, 8'h80);
    enable = 1'b1;
    n = 0;
    while (pop_cnt < 2 && n < 20) begin step(); n++; end
    rst = 1'b1;
    #1;
    check("t6_rd_in_rst", bus.q_rd_en, 0);
    step();
    rst = 1'b0;
    #1;
    check("t6_valid_after", bus.out_valid, 0);
    check("t6_rd_after", bus.q_rd_en, 0);
    check("t6_busy_after", busy, 0);
    clear_logs();
    wait_drain("t6", 80);
    check("t6_first_grant", first_pop_q, 1);
    er = '{1*16 + 4, 3*16 + 4, 1*16 + 2};
    check_runs("t6", er);
    check("t6_nwords", rx_data.size(), 10);
    if (rx_data.size() > 0) check("t6_first_word", rx_data[0], 8'h72);

    check("onehot_rd_en", onehot_err, 0);
    check("no_underflow", underflow_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
